// File: rtl/maxpool2_stream.sv
// maxpool2_stream
// ---------------------------------------------------------------------------
// Streaming 2x2 / stride-2 signed max-pool placed after the conv2 stage.
// Takes an IN_SIZE x IN_SIZE raster pixel stream and emits the
// OUT_SIZE x OUT_SIZE pooled map in raster order, then pulses done.
// Only a half-row line buffer of horizontal pair maxima is stored.
//
// Ports
//   clock      rising-edge clock
//   nreset     synchronous reset, active HIGH (1 at a rising edge resets)
//   start      one-cycle pulse, begins a frame (honoured only when idle)
//   in_valid   / in_ready  / in_data   : input pixel stream
//   out_valid  / out_ready / out_data  : pooled pixel stream
//   out_last   high with the final pooled pixel of the frame
//   busy       high while a frame is in progress (RUN or DRAIN)
//   done       one-cycle pulse when the frame has fully drained
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. out_valid stays high and out_data stays stable until the
// consumer takes it; in_ready never depends on in_valid.
// ---------------------------------------------------------------------------
module maxpool2_stream #(
    parameter int WIDTH_BIT = 16,
    parameter int IN_SIZE   = 318
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_BIT-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_BIT-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int OUT_SIZE = IN_SIZE / 2;
    localparam int CW       = ($clog2(IN_SIZE) > 2) ? $clog2(IN_SIZE) : 2;
    localparam int AW       = CW - 1;
    localparam int LB_DEPTH = 1 << AW;

    localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(2 * OUT_SIZE - 1);
    localparam bit            IN_ODD   = (IN_SIZE % 2) == 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic signed [WIDTH_BIT-1:0] smax(
        input logic signed [WIDTH_BIT-1:0] a,
        input logic signed [WIDTH_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    state_t                       state_q, state_d;
    logic [CW-1:0]                row_q, row_d;
    logic [CW-1:0]                col_q, col_d;
    logic signed [WIDTH_BIT-1:0]  hold_q, hold_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [WIDTH_BIT-1:0]  out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic                         done_q, done_d;

    // Line buffer: one horizontal pair maximum per output column.
    logic signed [WIDTH_BIT-1:0]  lb_q [LB_DEPTH];
    logic                         lb_we;
    logic [AW-1:0]                lb_addr;
    logic signed [WIDTH_BIT-1:0]  lb_wdata;
    logic signed [WIDTH_BIT-1:0]  lb_rdata;

    logic signed [WIDTH_BIT-1:0]  pix;
    logic signed [WIDTH_BIT-1:0]  pair_max;
    logic                         out_fire;
    logic                         accept;
    logic                         in_window;

    assign pix      = in_data;
    assign pair_max = smax(hold_q, pix);
    assign lb_addr  = col_q[CW-1:1];
    assign lb_rdata = lb_q[lb_addr];

    // A full output register only blocks input when it cannot drain this
    // cycle; a same-cycle drain lets a new window completion reload it.
    assign in_ready = (state_q == S_RUN) && !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // With an odd side the last row and column have no partner pixel;
    // they are accepted and dropped.
    assign in_window = !(IN_ODD && ((row_q == LAST_IDX) || (col_q == LAST_IDX)));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q && !out_fire;
        out_last_d  = out_last_q && !out_fire;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        lb_we       = 1'b0;
        lb_wdata    = pair_max;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (in_window) begin
                        if (!col_q[0]) begin
                            hold_d = pix;
                        end else if (!row_q[0]) begin
                            lb_we = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = smax(lb_rdata, pair_max);
                            out_last_d  = (row_q == WIN_LAST) && (col_q == WIN_LAST);
                        end
                    end
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once nothing is pending or the last output leaves now.
                if (!out_valid_q || out_fire) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Line buffer contents need no reset: every entry is written in an even
    // row before it is read in the following odd row.
    always_ff @(posedge clock) begin
        if (lb_we) begin
            lb_q[lb_addr] <= lb_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_maxpool2_stream.sv
module tb_maxpool2_stream;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: IN_SIZE = 4
  logic         start_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic         out_last_a, busy_a, done_a;
  logic [W-1:0] in_data_a, out_data_a;
  // instance B: IN_SIZE = 5
  logic         start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic         out_last_b, busy_b, done_b;
  logic [W-1:0] in_data_b, out_data_b;

  maxpool2_stream #(.WIDTH_BIT(W), .IN_SIZE(4)) u_a (
    .clock(clk), .nreset(rst), .start(start_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a), .done(done_a)
  );

  maxpool2_stream #(.WIDTH_BIT(W), .IN_SIZE(5)) u_b (
    .clock(clk), .nreset(rst), .start(start_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b), .done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a_q[$];
  bit           last_a_q[$];
  logic [W-1:0] got_b_q[$];
  bit           last_b_q[$];
  int done_cnt_a = 0, done_cyc_a = 0, xfer_cyc_a = 0;
  int done_cnt_b = 0, done_cyc_b = 0, acc_cnt_b = 0, acc_cyc_b = 0;

  // monitor: a handshake seen at a falling edge completes at the next rise
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && out_ready_a) begin
        got_a_q.push_back(out_data_a);
        last_a_q.push_back(out_last_a);
        xfer_cyc_a = cyc;
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
      if (out_valid_b && out_ready_b) begin
        got_b_q.push_back(out_data_b);
        last_b_q.push_back(out_last_b);
      end
      if (in_valid_b && in_ready_b) begin
        acc_cnt_b++;
        acc_cyc_b = cyc;
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
    end
  end

  // driver tasks (all start and end at posedge + 1)
  task automatic pulse_start_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic feed_a(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      int guard;
      guard = 0;
      in_valid_a = 1'b1;
      in_data_a  = W'(first + i);
      @(negedge clk);
      while (!in_ready_a && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        n_vec++; n_err++;
        $display("FAIL feed_a_timeout pixel %0d: in_ready stayed 0, required 1", i);
      end
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
  endtask

  task automatic feed_b(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      int guard;
      guard = 0;
      in_valid_b = 1'b1;
      in_data_b  = W'(first + i);
      @(negedge clk);
      while (!in_ready_b && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        n_vec++; n_err++;
        $display("FAIL feed_b_timeout pixel %0d: in_ready stayed 0, required 1", i);
      end
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
  endtask

  task automatic wait_done_a(input int prev);
    int guard;
    guard = 0;
    while (done_cnt_a == prev && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt_a == prev) begin
      n_vec++; n_err++;
      $display("FAIL wait_done_a: done never pulsed within 50 cycles");
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready_a); end
    n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid_a); end
    n_vec++; if (out_data_a !== 16'd0) begin n_err++; $display("FAIL reset_out_data got %0d exp 0", out_data_a); end
    n_vec++; if (out_last_a !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b exp 0", out_last_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done_a); end
    n_vec++; if (in_ready_b !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_b got %b exp 0", in_ready_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_ascending();
    int d0;
    got_a_q.delete(); last_a_q.delete();
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    d0 = done_cnt_a;
    pulse_start_a();
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL asc_busy got %b exp 1", busy_a); end
    feed_a(0, 16);
    wait_done_a(d0);
    n_vec++; if (got_a_q.size() != exp_q.size()) begin n_err++; $display("FAIL asc_count got %0d exp %0d", got_a_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_a_q.size()) begin
        n_vec++; if (got_a_q[i] !== exp_q[i]) begin n_err++; $display("FAIL asc_data[%0d] got %0d exp %0d", i, $signed(got_a_q[i]), $signed(exp_q[i])); end
        n_vec++; if (last_a_q[i] !== (i == exp_q.size() - 1)) begin n_err++; $display("FAIL asc_last[%0d] got %b exp %b", i, last_a_q[i], (i == exp_q.size() - 1)); end
      end
    end
    n_vec++; if (done_cyc_a != xfer_cyc_a + 1) begin n_err++; $display("FAIL asc_done_timing got cycle %0d exp %0d", done_cyc_a, xfer_cyc_a + 1); end
    n_vec++; if (done_cnt_a != d0 + 1) begin n_err++; $display("FAIL asc_done_count got %0d exp %0d", done_cnt_a, d0 + 1); end
    @(posedge clk); #1;
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL asc_busy_after got %b exp 0", busy_a); end
  endtask

  task automatic test_negative();
    int d0;
    got_a_q.delete(); last_a_q.delete();
    exp_q = '{W'(-11), W'(-9), W'(-3), W'(-1)};
    d0 = done_cnt_a;
    pulse_start_a();
    feed_a(-16, 16);
    wait_done_a(d0);
    n_vec++; if (got_a_q.size() != exp_q.size()) begin n_err++; $display("FAIL neg_count got %0d exp %0d", got_a_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_a_q.size()) begin
        n_vec++; if (got_a_q[i] !== exp_q[i]) begin n_err++; $display("FAIL neg_data[%0d] got %0d exp %0d", i, $signed(got_a_q[i]), $signed(exp_q[i])); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_odd_size();
    int d0, a0, guard;
    got_b_q.delete(); last_b_q.delete();
    exp_q = '{16'd6, 16'd8, 16'd16, 16'd18};
    d0 = done_cnt_b;
    a0 = acc_cnt_b;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    feed_b(0, 25);
    guard = 0;
    while (done_cnt_b == d0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++; if (done_cnt_b != d0 + 1) begin n_err++; $display("FAIL odd_done_count got %0d exp %0d", done_cnt_b, d0 + 1); end
    n_vec++; if (acc_cnt_b - a0 != 25) begin n_err++; $display("FAIL odd_accepted got %0d exp 25", acc_cnt_b - a0); end
    n_vec++; if (done_cyc_b != acc_cyc_b + 2) begin n_err++; $display("FAIL odd_done_timing got cycle %0d exp %0d", done_cyc_b, acc_cyc_b + 2); end
    n_vec++; if (got_b_q.size() != exp_q.size()) begin n_err++; $display("FAIL odd_count got %0d exp %0d", got_b_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_b_q.size()) begin
        n_vec++; if (got_b_q[i] !== exp_q[i]) begin n_err++; $display("FAIL odd_data[%0d] got %0d exp %0d", i, $signed(got_b_q[i]), $signed(exp_q[i])); end
        n_vec++; if (last_b_q[i] !== (i == exp_q.size() - 1)) begin n_err++; $display("FAIL odd_last[%0d] got %b exp %b", i, last_b_q[i], (i == exp_q.size() - 1)); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int d0;
    got_a_q.delete(); last_a_q.delete();
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    d0 = done_cnt_a;
    out_ready_a = 1'b0;
    pulse_start_a();
    feed_a(0, 6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b exp 1", k, out_valid_a); end
      n_vec++; if (out_data_a !== 16'd5) begin n_err++; $display("FAIL stall_data[%0d] got %0d exp 5", k, $signed(out_data_a)); end
      n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b exp 0", k, in_ready_a); end
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    feed_a(6, 10);
    wait_done_a(d0);
    n_vec++; if (got_a_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d exp %0d", got_a_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_a_q.size()) begin
        n_vec++; if (got_a_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_out[%0d] got %0d exp %0d", i, $signed(got_a_q[i]), $signed(exp_q[i])); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt_a;
    pulse_start_a();
    feed_a(0, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got_a_q.delete(); last_a_q.delete();
    @(negedge clk);
    n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b exp 0", out_valid_a); end
    n_vec++; if (out_data_a !== 16'd0) begin n_err++; $display("FAIL midrst_out_data got %0d exp 0", $signed(out_data_a)); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy_a); end
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready got %b exp 0", in_ready_a); end
    repeat (3) @(negedge clk);
    n_vec++; if (done_cnt_a != d0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses exp 0", done_cnt_a - d0); end
    @(posedge clk); #1;
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    pulse_start_a();
    feed_a(0, 16);
    wait_done_a(d0);
    n_vec++; if (got_a_q.size() != exp_q.size()) begin n_err++; $display("FAIL midrst_count got %0d exp %0d", got_a_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_a_q.size()) begin
        n_vec++; if (got_a_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_data[%0d] got %0d exp %0d", i, $signed(got_a_q[i]), $signed(exp_q[i])); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_run();
    int d0;
    got_a_q.delete(); last_a_q.delete();
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    d0 = done_cnt_a;
    pulse_start_a();
    feed_a(0, 8);
    pulse_start_a();
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rerun_busy got %b exp 1", busy_a); end
    feed_a(8, 8);
    wait_done_a(d0);
    n_vec++; if (got_a_q.size() != exp_q.size()) begin n_err++; $display("FAIL rerun_count got %0d exp %0d", got_a_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_a_q.size()) begin
        n_vec++; if (got_a_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rerun_data[%0d] got %0d exp %0d", i, $signed(got_a_q[i]), $signed(exp_q[i])); end
      end
    end
    n_vec++; if (done_cnt_a != d0 + 1) begin n_err++; $display("FAIL rerun_done_count got %0d exp %0d", done_cnt_a, d0 + 1); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    test_reset();
    test_ascending();
    test_negative();
    test_odd_size();
    test_backpressure();
    test_reset_mid_frame();
    test_start_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
